// File: rtl/br_pkg.sv
// Shared constants for branch resolution: condition bit positions and
// 2-bit history counter encodings, plus the saturating counter step.
package br_pkg;

    localparam int BR_W    = 6;
    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLEZ = 2;
    localparam int BR_BGTZ = 3;
    localparam int BR_BLTZ = 4;
    localparam int BR_BGEZ = 5;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic [1:0] cnt_next(
        input logic [1:0] c,
        input logic       t
    );
        if (t)
            return (c == CNT_ST) ? CNT_ST : c + 2'd1;
        else
            return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: 2-bit saturating counters, one combinational
// read port for fetch and one update port for resolution.
module br_bht
    import br_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] cnt [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= CNT_WNT;
        end else if (upd_en) begin
            cnt[upd_idx] <= cnt_next(cnt[upd_idx], upd_taken);
        end
    end

    // Read sees the registered table, so a same-cycle update is not visible yet
    assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/br_resolve.sv
// EX-stage branch resolution: condition evaluation, target adder,
// mispredict detection and ownership of the branch history table.
module br_resolve
    import br_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int BHT_IDX_W  = 4,
    parameter bit DELAY_SLOT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic [15:0]     offset,
    input  logic [BR_W-1:0] branch,
    input  logic            pred_taken_in,
    input  logic            flush,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic            out_valid,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);

    logic [XLEN-1:0]      sext;
    logic [XLEN-1:0]      tgt;
    logic [XLEN-1:0]      fall;
    logic                 eq;
    logic                 neg;
    logic                 zero;
    logic                 cond;
    logic                 go;
    logic                 pred_r;
    logic [BHT_IDX_W-1:0] idx_r;
    logic [1:0]           rd_cnt;
    logic                 unused_lookup;

    always_comb begin
        sext = {{(XLEN-16){offset[15]}}, offset};
        tgt  = pc + XLEN'(4) + (sext << 2);
        fall = pc + (DELAY_SLOT ? XLEN'(8) : XLEN'(4));
        eq   = (rs == rt);
        neg  = rs[XLEN-1];
        zero = (rs == '0);
        cond = (branch[BR_BEQ]  &  eq)
             | (branch[BR_BNE]  & ~eq)
             | (branch[BR_BLEZ] & (neg | zero))
             | (branch[BR_BGTZ] & ~neg & ~zero)
             | (branch[BR_BLTZ] &  neg)
             | (branch[BR_BGEZ] & ~neg);
    end

    // A branch arriving together with a flush is dropped like the in-flight one
    assign go = in_valid & (|branch) & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            taken       <= 1'b0;
            target      <= '0;
            redirect_pc <= '0;
            pred_r      <= 1'b0;
            idx_r       <= '0;
        end else if (en) begin
            out_valid <= go;
            if (go) begin
                taken       <= cond;
                target      <= tgt;
                redirect_pc <= cond ? tgt : fall;
                pred_r      <= pred_taken_in;
                idx_r       <= pc[BHT_IDX_W+1:2];
            end
        end
    end

    assign mispredict = out_valid & (taken ^ pred_r);

    br_bht #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .upd_en   (en & out_valid & ~flush),
        .upd_idx  (idx_r),
        .upd_taken(taken),
        .rd_idx   (lookup_pc[BHT_IDX_W+1:2]),
        .rd_cnt   (rd_cnt)
    );

    assign pred_taken = rd_cnt[1];

    assign unused_lookup = ^{lookup_pc[XLEN-1:BHT_IDX_W+2], lookup_pc[1:0],
                             rd_cnt[0]};

endmodule

// File: tb/tb_br_resolve.sv
// Bench for br_resolve: directed vector table, hand sequences for the BHT,
// flush, stall and reset corners, and a randomized run against a model.
module tb_br_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] offset;
    logic [5:0]  branch;
    logic        pred_taken_in;
    logic        flush;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic        out_valid;
    logic        taken;
    logic [31:0] target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    br_resolve dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in_valid     (in_valid),
        .pc           (pc),
        .rs           (rs),
        .rt           (rt),
        .offset       (offset),
        .branch       (branch),
        .pred_taken_in(pred_taken_in),
        .flush        (flush),
        .lookup_pc    (lookup_pc),
        .pred_taken   (pred_taken),
        .out_valid    (out_valid),
        .taken        (taken),
        .target       (target),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: last resolved branch and the counter table as integers
    bit          m_valid;
    bit          m_taken;
    bit          m_pred;
    logic [31:0] m_target;
    logic [31:0] m_redir;
    int          m_idx;
    int          m_bht [16];

    typedef struct {
        logic [5:0]  br;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] off;
        bit          pred;
        bit          taken;
        logic [31:0] target;
        bit          misp;
        logic [31:0] redir;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit m_cond(input logic [5:0] br,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        int sa;
        bit r;
        sa = a;
        r  = 0;
        if (br[0] && a == b) r = 1;
        if (br[1] && a != b) r = 1;
        if (br[2] && sa <= 0) r = 1;
        if (br[3] && sa > 0) r = 1;
        if (br[4] && sa < 0) r = 1;
        if (br[5] && sa >= 0) r = 1;
        return r;
    endfunction

    function automatic void m_reset();
        m_valid  = 0;
        m_taken  = 0;
        m_pred   = 0;
        m_target = 0;
        m_redir  = 0;
        m_idx    = 0;
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
    endfunction

    task automatic cyc(input bit e, input bit iv, input logic [5:0] br,
                       input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] off,
                       input bit pr, input bit fl, input logic [31:0] lpc);
        @(negedge clk);
        en = e; in_valid = iv; branch = br; pc = p; rs = a; rt = b;
        offset = off; pred_taken_in = pr; flush = fl; lookup_pc = lpc;
        #1;
        chk("pred_taken", 32'(pred_taken), 32'(m_bht[lpc[5:2]] >= 2));
        @(posedge clk);
        if (e) begin
            if (m_valid && !fl) begin
                if (m_taken) begin
                    if (m_bht[m_idx] < 3) m_bht[m_idx]++;
                end else if (m_bht[m_idx] > 0) begin
                    m_bht[m_idx]--;
                end
            end
            m_valid = iv && br != 0 && !fl;
            if (m_valid) begin
                m_taken  = m_cond(br, a, b);
                m_target = p + 32'd4 + 32'($signed(off)) * 32'd4;
                m_redir  = m_taken ? m_target : p + 32'd8;
                m_pred   = pr;
                m_idx    = int'(p[5:2]);
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("mispredict", 32'(mispredict), 32'(m_valid && m_taken != m_pred));
        if (m_valid) begin
            chk("taken", 32'(taken), 32'(m_taken));
            chk("target", target, m_target);
            chk("redirect_pc", redirect_pc, m_redir);
        end
    endtask

    task automatic idle(input logic [31:0] lpc);
        cyc(1, 0, 6'b0, 0, 0, 0, 16'h0, 0, 0, lpc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        m_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  br;
        bit          exp_seq [4];

        tbl[0] = '{6'b000001, 32'h100, 32'd5, 32'd5, 16'h0004, 0,
                   1, 32'h114, 1, 32'h114};
        tbl[1] = '{6'b010000, 32'h200, 32'hFFFFFFFF, 32'd0, 16'h0000, 1,
                   1, 32'h204, 0, 32'h204};
        tbl[2] = '{6'b100000, 32'h300, 32'd0, 32'd9, 16'h0001, 0,
                   1, 32'h308, 1, 32'h308};
        tbl[3] = '{6'b001000, 32'h400, 32'd0, 32'd0, 16'h0002, 0,
                   0, 32'h40C, 0, 32'h408};
        tbl[4] = '{6'b000010, 32'h0, 32'd7, 32'd7, 16'h8000, 1,
                   0, 32'hFFFE0004, 1, 32'h8};
        tbl[5] = '{6'b000100, 32'h500, 32'h80000000, 32'd0, 16'hFFFF, 1,
                   1, 32'h500, 0, 32'h500};
        tbl[6] = '{6'b001001, 32'h600, 32'd3, 32'd4, 16'h0010, 0,
                   1, 32'h644, 1, 32'h644};
        exp_seq = '{0, 1, 1, 1};

        rst = 1'b0; en = 0; in_valid = 0; pc = 0; rs = 0; rt = 0;
        offset = 0; branch = 0; pred_taken_in = 0; flush = 0; lookup_pc = 0;
        m_reset();
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_taken", 32'(taken), 0);
        chk("rst_mispredict", 32'(mispredict), 0);
        chk("rst_target", target, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_pred", 32'(pred_taken), 0);
        @(negedge clk);
        rst = 1'b1;

        // Three taken branches at 0x40 walk the counter 01 -> 10 -> 11 -> 11
        for (int k = 0; k < 4; k++) begin
            if (k < 3) cyc(1, 1, 6'b000001, 32'h40, 1, 1, 16'h1, 0, 0, 32'h40);
            else idle(32'h40);
            chk("bht_seq", 32'(pred_taken), 32'(exp_seq[k]));
        end

        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, tbl[i].br, tbl[i].pc, tbl[i].rs, tbl[i].rt,
                tbl[i].off, tbl[i].pred, 0, 32'h0);
            chk("tbl_taken", 32'(taken), 32'(tbl[i].taken));
            chk("tbl_target", target, tbl[i].target);
            chk("tbl_misp", 32'(mispredict), 32'(tbl[i].misp));
            chk("tbl_redirect", redirect_pc, tbl[i].redir);
        end
        cyc(1, 1, 6'b0, 32'h700, 1, 1, 16'h1, 1, 0, 32'h0);
        chk("nonbranch_valid", 32'(out_valid), 0);

        // Flush on the edge after accept: result dropped, counter untouched
        do_reset();
        cyc(1, 1, 6'b000001, 32'h80, 2, 2, 16'h3, 0, 0, 32'h80);
        cyc(1, 1, 6'b000001, 32'h84, 2, 2, 16'h3, 0, 1, 32'h80);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_bht", 32'(pred_taken), 0);
        idle(32'h84);
        chk("flush_new_dropped", 32'(pred_taken), 0);

        // Stall: outputs and table hold for three cycles, then update proceeds
        cyc(1, 1, 6'b010000, 32'h90, 32'hFFFFFFFF, 0, 16'h0, 0, 0, 32'h90);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 6'b000010, 32'h94, 1, 2, 16'h7, 1, 0, 32'h90);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_misp", 32'(mispredict), 1);
            chk("hold_target", target, 32'h94);
            chk("hold_bht", 32'(pred_taken), 0);
        end
        idle(32'h90);
        chk("post_hold_bht", 32'(pred_taken), 1);

        for (int n = 0; n < 400; n++) begin
            case ($urandom % 6)
                0: ra = 0;
                1: ra = 1;
                2: ra = 32'hFFFFFFFF;
                3: ra = 32'h80000000;
                4: ra = 32'h7FFFFFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom % 2 == 0) ? ra : $urandom;
            case ($urandom % 4)
                0: br = 6'b0;
                3: br = 6'($urandom);
                default: br = 6'(1 << $urandom_range(0, 5));
            endcase
            v = {$urandom_range(0, 63), 2'b00};
            cyc(($urandom % 8) != 0, ($urandom % 4) != 0, br, v, ra, rb,
                16'($urandom), 1'($urandom), ($urandom % 10) == 0,
                {$urandom_range(0, 63), 2'b00});
        end

        // Asynchronous reset between edges with a result in flight
        cyc(1, 1, 6'b000001, 32'h44, 1, 1, 16'h5, 0, 0, 32'h44);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_misp", 32'(mispredict), 0);
        chk("arst_taken", 32'(taken), 0);
        chk("arst_target", target, 0);
        chk("arst_redirect", redirect_pc, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lookup_pc = 32'(i * 4);
            #1;
            chk("arst_bht", 32'(pred_taken), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
